// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchronizer, stability-counter debounce, and
// long-press / auto-repeat event generation. All outputs are registered.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic long_active
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_P = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DB_N = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LG_N = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] RP_N = CW'(REPEAT_CYCLES);
  localparam bit DB_ONE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [2:0] {
    IDLE, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT
  } state_t;

  state_t        state;
  logic          ff1, sync;
  logic          origin;   // 1: release wait entered from HELD
  logic [CW-1:0] db_cnt, hold_cnt, rep_cnt;
  logic [CW-1:0] db_inc, hold_inc, rep_inc;
  logic          rel_now;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign db_inc   = sat_inc(db_cnt);
  assign hold_inc = sat_inc(hold_cnt);
  assign rep_inc  = sat_inc(rep_cnt);

  // Release is accepted either when the wait count completes, or immediately
  // on the first low sample when a single sample is enough to debounce.
  assign rel_now = !sync &&
                   ((state == RELEASE_WAIT && db_inc == DB_N) ||
                    ((state == PRESSED || state == HELD) && DB_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1  <= 1'b0;
      sync <= 1'b0;
    end else begin
      ff1  <= btn_raw;
      sync <= ff1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      origin        <= 1'b0;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      level         <= 1'b0;
      long_active   <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (rel_now) begin
        state         <= IDLE;
        release_pulse <= 1'b1;
        level         <= 1'b0;
        long_active   <= 1'b0;
        db_cnt        <= '0;
        hold_cnt      <= '0;
        rep_cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (sync) begin
              if (DB_ONE) begin
                state       <= PRESSED;
                press_pulse <= 1'b1;
                level       <= 1'b1;
                hold_cnt    <= '0;
              end else begin
                state  <= PRESS_WAIT;
                db_cnt <= CW'(1);
              end
            end
          end
          PRESS_WAIT: begin
            if (!sync) begin
              state  <= IDLE;
              db_cnt <= '0;
            end else if (db_inc == DB_N) begin
              state       <= PRESSED;
              press_pulse <= 1'b1;
              level       <= 1'b1;
              hold_cnt    <= '0;
              db_cnt      <= '0;
            end else begin
              db_cnt <= db_inc;
            end
          end
          PRESSED: begin
            if (!sync) begin
              state  <= RELEASE_WAIT;
              origin <= 1'b0;
              db_cnt <= CW'(1);
            end else if (hold_inc == LG_N) begin
              state       <= HELD;
              long_pulse  <= 1'b1;
              long_active <= 1'b1;
              hold_cnt    <= hold_inc;
              rep_cnt     <= '0;
            end else begin
              hold_cnt <= hold_inc;
            end
          end
          HELD: begin
            if (!sync) begin
              state  <= RELEASE_WAIT;
              origin <= 1'b1;
              db_cnt <= CW'(1);
            end else if (rep_inc == RP_N) begin
              repeat_pulse <= REPEAT_EN;
              rep_cnt      <= '0;
            end else begin
              rep_cnt <= rep_inc;
            end
          end
          RELEASE_WAIT: begin
            // Bounce back high: frozen hold/repeat counters resume as they were.
            if (sync) begin
              state  <= origin ? HELD : PRESSED;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
